// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronise, debounce and edge-detect user pins with a coalescing change event
module input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 48000
) (
    input  logic             clk,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] inputs_i,
    output logic [WIDTH-1:0] inputs_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [WIDTH-1:0] evt_data_o,
    output logic             evt_overrun_o
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] next_lvl;
    logic             chg;

    assign s = sync_q[SYNC_STAGES-1];

    // Plain flop chain per bit; nothing may sit between the stages.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= inputs_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // A bit flips when its counter has already seen DEBOUNCE_CYCLES-1 differing cycles and this one differs too.
    always_comb begin
        upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upd[i] = (s[i] != inputs_o[i]) && (cnt_q[i] == CNT_LAST);
        end
        next_lvl = inputs_o ^ upd;
        chg      = |upd;
    end

    // Per-bit run counter of consecutive cycles where the synced pin disagrees with the stable level.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == inputs_o[i] || cnt_q[i] == CNT_LAST) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Stable levels and their edge pulses, all registered together so they line up in the same cycle.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            inputs_o <= '0;
            rise_o   <= '0;
            fall_o   <= '0;
        end else begin
            inputs_o <= next_lvl;
            rise_o   <= upd & next_lvl;
            fall_o   <= upd & ~next_lvl;
        end
    end

    // Single-entry event slot: a new change overwrites an unaccepted one and flags the overrun.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            evt_valid_o   <= 1'b0;
            evt_data_o    <= '0;
            evt_overrun_o <= 1'b0;
        end else if (chg) begin
            evt_valid_o   <= 1'b1;
            evt_data_o    <= next_lvl;
            evt_overrun_o <= evt_valid_o & ~evt_ready_i;
        end else if (evt_valid_o && evt_ready_i) begin
            evt_valid_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - self-checking bench for input_conditioner
module tb_input_conditioner;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rstn_i;
    logic [W-1:0] inputs_i;
    logic [W-1:0] inputs_o;
    logic [W-1:0] rise_o;
    logic [W-1:0] fall_o;
    logic         evt_valid_o;
    logic         evt_ready_i;
    logic [W-1:0] evt_data_o;
    logic         evt_overrun_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .WIDTH(W),
        .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rstn_i(rstn_i),
        .inputs_i(inputs_i),
        .inputs_o(inputs_o),
        .rise_o(rise_o),
        .fall_o(fall_o),
        .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i),
        .evt_data_o(evt_data_o),
        .evt_overrun_o(evt_overrun_o)
    );

    logic [33:0] obs;
    assign obs = {inputs_o, rise_o, fall_o, evt_valid_o, evt_data_o, evt_overrun_o};

    // Reference model: pin history per edge; a level is accepted once the pin,
    // seen through the synchroniser delay, disagreed with it for DC straight edges.
    logic [W-1:0] hist [SS+DC];
    logic [W-1:0] m_lvl, m_rise, m_fall, m_data;
    logic         m_valid, m_ovr;
    logic [33:0]  m_all;
    assign m_all = {m_lvl, m_rise, m_fall, m_valid, m_data, m_ovr};

    always @(posedge clk) begin : model
        logic [W-1:0] diff;
        logic         v;
        if (!rstn_i) begin
            for (int k = 0; k < SS + DC; k++) hist[k] = '0;
            m_lvl = '0; m_rise = '0; m_fall = '0;
            m_valid = 1'b0; m_data = '0; m_ovr = 1'b0;
        end else begin
            for (int k = SS + DC - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = inputs_i;
            diff = '1;
            for (int k = SS; k < SS + DC; k++) diff = diff & (hist[k] ^ m_lvl);
            m_lvl  = m_lvl ^ diff;
            m_rise = diff & m_lvl;
            m_fall = diff & ~m_lvl;
            v = m_valid;
            if (v && evt_ready_i) v = 1'b0;
            if (diff != '0) begin
                m_ovr  = v;
                m_data = m_lvl;
                v      = 1'b1;
            end
            m_valid = v;
        end
    end

    task automatic test_reset();
        @(negedge clk);
        inputs_i = 8'hA5;
        repeat (8) @(negedge clk);
        checks++;
        if (inputs_o !== 8'hA5) begin
            failures++;
            $display("FAIL reset_pre_level: got %h expected %h", inputs_o, 8'hA5);
        end
        @(posedge clk);
        #3;
        rstn_i   = 1'b0;
        inputs_i = 8'h00;
        #1;
        checks++;
        if (obs !== 34'h0) begin
            failures++;
            $display("FAIL reset_async: got %h expected %h", obs, 34'h0);
        end
        repeat (2) @(negedge clk);
        rstn_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== 34'h0) begin
                failures++;
                $display("FAIL reset_release cycle %0d: got %h expected %h", c, obs, 34'h0);
            end
        end
    endtask

    task automatic test_single_rise();
        int lat;
        lat = 0;
        @(negedge clk);
        evt_ready_i = 1'b0;
        inputs_i    = 8'h01;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (inputs_o !== 8'h00) lat = k;
        end
        checks++;
        if (lat !== 6 || inputs_o !== 8'h01) begin
            failures++;
            $display("FAIL rise_latency: got %0d edges level %h expected 6 edges level 01", lat, inputs_o);
        end
        checks++;
        if ({rise_o, fall_o} !== 16'h0100) begin
            failures++;
            $display("FAIL rise_pulse: got rise %h fall %h expected rise 01 fall 00", rise_o, fall_o);
        end
        checks++;
        if ({evt_valid_o, evt_data_o, evt_overrun_o} !== {1'b1, 8'h01, 1'b0}) begin
            failures++;
            $display("FAIL rise_event: got v%b d%h o%b expected v1 d01 o0", evt_valid_o, evt_data_o, evt_overrun_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rise_o !== 8'h00) begin
            failures++;
            $display("FAIL rise_one_cycle: got %h expected 00", rise_o);
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        inputs_i = 8'h09;
        repeat (3) @(negedge clk);
        inputs_i = 8'h01;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== {8'h01, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0}) begin
                failures++;
                $display("FAIL glitch cycle %0d: got %h expected %h", c, obs, {8'h01, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0});
            end
        end
    endtask

    task automatic test_coalesce();
        @(negedge clk);
        inputs_i = 8'h03;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (obs !== {8'h03, 8'h02, 8'h00, 1'b1, 8'h03, 1'b1}) begin
            failures++;
            $display("FAIL coalesce: got %h expected %h", obs, {8'h03, 8'h02, 8'h00, 1'b1, 8'h03, 1'b1});
        end
        @(negedge clk);
        evt_ready_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({evt_valid_o, evt_data_o, evt_overrun_o} !== {1'b0, 8'h03, 1'b1}) begin
            failures++;
            $display("FAIL coalesce_accept: got v%b d%h o%b expected v0 d03 o1", evt_valid_o, evt_data_o, evt_overrun_o);
        end
        @(negedge clk);
        evt_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        inputs_i = 8'h01;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (obs !== {8'h01, 8'h00, 8'h02, 1'b1, 8'h01, 1'b0}) begin
            failures++;
            $display("FAIL b2b_setup: got %h expected %h", obs, {8'h01, 8'h00, 8'h02, 1'b1, 8'h01, 1'b0});
        end
        @(negedge clk);
        inputs_i = 8'h00;
        repeat (5) @(negedge clk);
        evt_ready_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== {8'h00, 8'h00, 8'h01, 1'b1, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL b2b_transfer: got %h expected %h", obs, {8'h00, 8'h00, 8'h01, 1'b1, 8'h00, 1'b0});
        end
        @(negedge clk);
        evt_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_debounce();
        int lat;
        lat = 0;
        @(negedge clk);
        inputs_i = 8'hFF;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (obs !== {8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL pre_reset_no_event: got %h expected %h", obs, {8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0});
        end
        #1;
        rstn_i = 1'b0;
        #1;
        checks++;
        if (obs !== 34'h0) begin
            failures++;
            $display("FAIL mid_reset_clear: got %h expected %h", obs, 34'h0);
        end
        repeat (2) @(negedge clk);
        rstn_i = 1'b1;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (inputs_o !== 8'h00) lat = k;
        end
        checks++;
        if (lat !== 6 || obs !== {8'hFF, 8'hFF, 8'h00, 1'b1, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL post_reset_rise: got %0d edges obs %h expected 6 edges obs %h", lat, obs, {8'hFF, 8'hFF, 8'h00, 1'b1, 8'hFF, 1'b0});
        end
    endtask

    task automatic test_random();
        int rate;
        rate = 10;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== m_all) begin
                failures++;
                $display("FAIL random cycle %0d: got %h expected %h", c, obs, m_all);
            end
            if (c % 100 == 0) rate = int'($urandom_range(3, 30));
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, rate - 1) == 0) inputs_i[b] = ~inputs_i[b];
            end
            evt_ready_i = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        evt_ready_i = 1'b0;
    endtask

    initial begin
        rstn_i      = 1'b0;
        inputs_i    = 8'h00;
        evt_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rstn_i = 1'b1;
        test_reset();
        test_single_rise();
        test_glitch();
        test_coalesce();
        test_back_to_back();
        test_reset_mid_debounce();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
